// File: rtl/rp_adc_pkg.sv
// rp_adc_pkg: shared defaults, accumulator sizing, full-scale constants and
// raw-code conversion for the rp_adc_capture front end.
package rp_adc_pkg;

   localparam int DEF_ADC_BITWIDTH = 14;
   localparam int DEF_MAX_LOG2_DEC = 4;

   // Accumulator must hold 2^max_log2 full-scale samples without wrapping.
   function automatic int acc_width(int w, int max_log2);
      return w + max_log2;
   endfunction

   // Two's complement full-scale code, valid in the low w bits.
   function automatic logic [31:0] full_scale(int w, bit neg);
      logic [31:0] one;
      one = 32'd1 << (w - 1);
      return neg ? (~one + 32'd1) : (one - 32'd1);
   endfunction

   // Offset binary to two's complement is a flip of the sign bit.
   function automatic logic [31:0] to_twos(logic [31:0] code, int w,
                                            int offset_bin);
      logic [31:0] msb;
      msb = 32'd1 << (w - 1);
      return (offset_bin != 0) ? (code ^ msb) : code;
   endfunction

endpackage

// File: rtl/rp_adc_avg_ch.sv
// rp_adc_avg_ch: one channel's conversion register, sticky clip flag and
// window accumulator with arithmetic-shift averaging.
// Ports: clk/rst (sync, active high); raw = stage-1 code; s_vld = converted
// sample is real; term = last sample of window; l = window log2 factor;
// clr_ovf = clear clip flag; dout = averaged sample; ovf = sticky clip flag.
module rp_adc_avg_ch
   import rp_adc_pkg::*;
#(
   parameter int W            = DEF_ADC_BITWIDTH,
   parameter int MAX_LOG2_DEC = DEF_MAX_LOG2_DEC,
   parameter int DEC_W        = 3,
   parameter int OFFSET_BIN   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [W-1:0]     raw,
   input  logic             s_vld,
   input  logic             term,
   input  logic [DEC_W-1:0] l,
   input  logic             clr_ovf,
   output logic [W-1:0]     dout,
   output logic             ovf
);

   localparam int ACC_W = acc_width(W, MAX_LOG2_DEC);
   localparam logic [W-1:0] FS_POS = W'(full_scale(W, 1'b0));
   localparam logic [W-1:0] FS_NEG = W'(full_scale(W, 1'b1));

   logic [W-1:0]            s;
   logic signed [ACC_W-1:0] s_ext;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic                    clip;

   assign s_ext = {{MAX_LOG2_DEC{s[W-1]}}, s};
   assign sum   = acc + s_ext;
   assign clip  = (s == FS_POS) || (s == FS_NEG);

   always_ff @(posedge clk) begin
      if (rst) begin
         s    <= '0;
         acc  <= '0;
         dout <= '0;
         ovf  <= 1'b0;
      end else begin
         s <= W'(to_twos(32'(raw), W, OFFSET_BIN));
         // s is garbage while the pipe fills (a zero raw code converts to
         // negative full scale), so only real samples may raise the flag.
         // A new clip beats a simultaneous clear.
         ovf <= (s_vld && clip) || (ovf && !clr_ovf);
         if (s_vld) begin
            if (term) begin
               dout <= W'(sum >>> l);
               acc  <= '0;
            end else begin
               acc <= sum;
            end
         end
      end
   end

endmodule

// File: rtl/rp_adc_capture.sv
// rp_adc_capture: multi-channel ADC front end; registers raw codes, converts
// to two's complement, averages 2^dec_log2 samples and flags clipping.
// Ports: adc_clk/rst (sync, active high); adc_in = packed raw codes;
// dec_log2 = averaging log2; clr_ovf = clear clip flags; adc_out/adc_valid =
// averaged samples and strobe; ovf_flags = sticky clips; adc_csn = tied high.
module rp_adc_capture
   import rp_adc_pkg::*;
#(
   parameter int ADC_BITWIDTH = DEF_ADC_BITWIDTH,
   parameter int N_CH         = 2,
   parameter int OFFSET_BIN   = 1,
   parameter int MAX_LOG2_DEC = DEF_MAX_LOG2_DEC,
   parameter int DEC_W        = 3
) (
   input  logic                         adc_clk,
   input  logic                         rst,
   input  logic [N_CH*ADC_BITWIDTH-1:0] adc_in,
   input  logic [DEC_W-1:0]             dec_log2,
   input  logic                         clr_ovf,
   output logic [N_CH*ADC_BITWIDTH-1:0] adc_out,
   output logic                         adc_valid,
   output logic [N_CH-1:0]              ovf_flags,
   output logic                         adc_csn
);

   localparam int CNT_W = (MAX_LOG2_DEC > 0) ? MAX_LOG2_DEC : 1;
   localparam logic [DEC_W-1:0] L_MAX = DEC_W'(MAX_LOG2_DEC);

   logic [N_CH*ADC_BITWIDTH-1:0] raw_q;
   logic                         raw_vld;
   logic                         s_vld;
   logic [CNT_W-1:0]             cnt;
   logic [CNT_W-1:0]             cnt_last;
   logic [DEC_W-1:0]             l_q;
   logic [DEC_W-1:0]             l_eff;
   logic                         term;

   // The factor is only sampled at a window start; mid-window it is frozen.
   always_comb begin
      l_eff = l_q;
      if (cnt == '0) begin
         l_eff = (dec_log2 > L_MAX) ? L_MAX : dec_log2;
      end
   end

   assign cnt_last = CNT_W'((32'd1 << l_eff) - 32'd1);
   assign term     = (cnt == cnt_last);
   assign adc_csn  = 1'b1;

   // raw_vld/s_vld track pipeline fill so the first window starts on the
   // first real converted sample.
   always_ff @(posedge adc_clk) begin
      if (rst) begin
         raw_q     <= '0;
         raw_vld   <= 1'b0;
         s_vld     <= 1'b0;
         cnt       <= '0;
         l_q       <= '0;
         adc_valid <= 1'b0;
      end else begin
         raw_q     <= adc_in;
         raw_vld   <= 1'b1;
         s_vld     <= raw_vld;
         l_q       <= l_eff;
         adc_valid <= s_vld && term;
         if (s_vld) begin
            cnt <= term ? '0 : cnt + CNT_W'(1);
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      rp_adc_avg_ch #(
         .W            (ADC_BITWIDTH),
         .MAX_LOG2_DEC (MAX_LOG2_DEC),
         .DEC_W        (DEC_W),
         .OFFSET_BIN   (OFFSET_BIN)
      ) u_ch (
         .clk     (adc_clk),
         .rst     (rst),
         .raw     (raw_q[k*ADC_BITWIDTH +: ADC_BITWIDTH]),
         .s_vld   (s_vld),
         .term    (term),
         .l       (l_eff),
         .clr_ovf (clr_ovf),
         .dout    (adc_out[k*ADC_BITWIDTH +: ADC_BITWIDTH]),
         .ovf     (ovf_flags[k])
      );
   end

endmodule
